// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared hazard-controller states and forward-select encodings
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_MWAIT  = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - ALU operand forward select for one EX source register
module fwd_select
  import riscv_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FWD_ENABLE = 1
) (
  input  logic [REG_AW-1:0] rs_ex,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic              regwrite_mem,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              regwrite_wb,
  output logic [1:0]        fwd
);

  // MEM is the younger producer so it wins over WB; x0 is never forwarded
  always_comb begin
    fwd = FWD_REG;
    if (FWD_ENABLE != 0) begin
      if (regwrite_mem && (rd_mem != '0) && (rd_mem == rs_ex)) begin
        fwd = FWD_MEM;
      end else if (regwrite_wb && (rd_wb != '0) && (rd_wb == rs_ex)) begin
        fwd = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard, forwarding and stall/flush control
module pipe_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int FWD_ENABLE = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              uses_rs1_id,
  input  logic              uses_rs2_id,
  input  logic [REG_AW-1:0] rs1_ex,
  input  logic [REG_AW-1:0] rs2_ex,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic              memread_ex,
  input  logic              regwrite_ex,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic              regwrite_mem,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              regwrite_wb,
  input  logic              pcsrc,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              stage_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic [1:0]        forwardA,
  output logic [1:0]        forwardB,
  output logic              pipeline_stall,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  // Detecting cycle is the first bubble, so LSTALL only covers the remainder
  localparam logic [1:0] LS_INIT = 2'(LOAD_STALL - 1);
  localparam bit         NO_FWD  = (FWD_ENABLE == 0);

  hz_state_e        state_q, state_d;
  hz_state_e        ret_state_q, ret_state_d;
  hz_state_e        eff_state;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [1:0]       fwd_a, fwd_b;
  logic             ex_hit, mem_hit, load_use, raw_stall;
  logic             freeze, branch, stall;

  fwd_select #(.REG_AW(REG_AW), .FWD_ENABLE(FWD_ENABLE)) u_fwd_a (
    .rs_ex        (rs1_ex),
    .rd_mem       (rd_mem),
    .regwrite_mem (regwrite_mem),
    .rd_wb        (rd_wb),
    .regwrite_wb  (regwrite_wb),
    .fwd          (fwd_a)
  );

  fwd_select #(.REG_AW(REG_AW), .FWD_ENABLE(FWD_ENABLE)) u_fwd_b (
    .rs_ex        (rs2_ex),
    .rd_mem       (rd_mem),
    .regwrite_mem (regwrite_mem),
    .rd_wb        (rd_wb),
    .regwrite_wb  (regwrite_wb),
    .fwd          (fwd_b)
  );

  assign forwardA = reset ? fwd_a : FWD_REG;
  assign forwardB = reset ? fwd_b : FWD_REG;

  // An ID source only matters when the instruction actually reads it; x0 never hazards
  assign ex_hit    = (rd_ex != '0) &&
                     ((uses_rs1_id && (rs1_id == rd_ex)) || (uses_rs2_id && (rs2_id == rd_ex)));
  assign mem_hit   = regwrite_mem && (rd_mem != '0) &&
                     ((uses_rs1_id && (rs1_id == rd_mem)) || (uses_rs2_id && (rs2_id == rd_mem)));
  assign load_use  = memread_ex && ex_hit;
  assign raw_stall = NO_FWD && ((regwrite_ex && ex_hit) || mem_hit);

  // Once memory is ready again, MWAIT behaves exactly like the state it interrupted
  assign eff_state = (state_q == ST_MWAIT) ? ret_state_q : state_q;

  // Next-state: mem_busy > pcsrc > remaining load stall > new load-use > no-forward RAW
  always_comb begin
    state_d     = eff_state;
    ret_state_d = ret_state_q;
    cnt_d       = cnt_q;
    freeze      = 1'b0;
    branch      = 1'b0;
    stall       = 1'b0;
    if (mem_busy) begin
      freeze      = 1'b1;
      ret_state_d = eff_state;
      state_d     = ST_MWAIT;
    end else if (pcsrc) begin
      branch  = 1'b1;
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (eff_state == ST_LSTALL) begin
      stall   = 1'b1;
      cnt_d   = cnt_q - 2'd1;
      state_d = (cnt_q == 2'd1) ? ST_RUN : ST_LSTALL;
    end else if (load_use) begin
      stall = 1'b1;
      if (LOAD_STALL > 1) begin
        state_d = ST_LSTALL;
        cnt_d   = LS_INIT;
      end
    end else if (raw_stall) begin
      stall = 1'b1;
    end
  end

  // Pipeline enables and flushes; reset holds every pipeline register cleared
  always_comb begin
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    stage_en       = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_flush   = 1'b0;
    pipeline_stall = 1'b0;
    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      stage_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (freeze) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      stage_en    = 1'b0;
    end else if (branch) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (stall) begin
      pc_write       = 1'b0;
      if_id_write    = 1'b0;
      id_ex_flush    = 1'b1;
      pipeline_stall = 1'b1;
    end
  end

  // Saturating performance counters; memory-wait cycles count as lost cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((stall || freeze) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (branch && (flush_cnt_q != '1))            flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State, return-state, stall counter and performance counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      ret_state_q <= ST_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;
  // {pc_write, if_id_write, stage_en, if_id_flush, id_ex_flush, ex_mem_flush, pipeline_stall}
  localparam logic [6:0] C_NORM   = 7'b1110000;
  localparam logic [6:0] C_STALL  = 7'b0010101;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_RESET  = 7'b0001110;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [AW-1:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic uses_rs1_id, uses_rs2_id, memread_ex, regwrite_ex, regwrite_mem, regwrite_wb;
  logic pcsrc, mem_busy;

  logic pcw_a, ifw_a, en_a, fi_a, fe_a, fm_a, st_a;
  logic [1:0] fa_a, fb_a;
  logic [15:0] sc_a, fc_a;
  logic pcw_b, ifw_b, en_b, fi_b, fe_b, fm_b, st_b;
  logic [1:0] fa_b, fb_b;
  logic [3:0] sc_b, fc_b;
  logic [10:0] ctl_a, ctl_b;

  int checks = 0;
  int fails = 0;
  int pend_a, ns_a, nf_a, pend_b, ns_b, nf_b;
  int es_a, ef_a, es_b, ef_b;
  logic [10:0] ea, eb;

  always #5 clk = ~clk;

  assign ctl_a = {pcw_a, ifw_a, en_a, fi_a, fe_a, fm_a, st_a, fa_a, fb_a};
  assign ctl_b = {pcw_b, ifw_b, en_b, fi_b, fe_b, fm_b, st_b, fa_b, fb_b};

  pipe_hazard_ctrl #(.REG_AW(AW), .LOAD_STALL(3), .FWD_ENABLE(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .memread_ex(memread_ex), .regwrite_ex(regwrite_ex),
    .rd_mem(rd_mem), .regwrite_mem(regwrite_mem), .rd_wb(rd_wb), .regwrite_wb(regwrite_wb),
    .pcsrc(pcsrc), .mem_busy(mem_busy),
    .pc_write(pcw_a), .if_id_write(ifw_a), .stage_en(en_a),
    .if_id_flush(fi_a), .id_ex_flush(fe_a), .ex_mem_flush(fm_a),
    .forwardA(fa_a), .forwardB(fb_a), .pipeline_stall(st_a),
    .stall_cycles(sc_a), .flush_events(fc_a)
  );

  pipe_hazard_ctrl #(.REG_AW(AW), .LOAD_STALL(1), .FWD_ENABLE(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .memread_ex(memread_ex), .regwrite_ex(regwrite_ex),
    .rd_mem(rd_mem), .regwrite_mem(regwrite_mem), .rd_wb(rd_wb), .regwrite_wb(regwrite_wb),
    .pcsrc(pcsrc), .mem_busy(mem_busy),
    .pc_write(pcw_b), .if_id_write(ifw_b), .stage_en(en_b),
    .if_id_flush(fi_b), .id_ex_flush(fe_b), .ex_mem_flush(fm_b),
    .forwardA(fa_b), .forwardB(fb_b), .pipeline_stall(st_b),
    .stall_cycles(sc_b), .flush_events(fc_b)
  );

  // ---------------- reference model ----------------
  function automatic bit id_reads(input logic [AW-1:0] rd, input logic we);
    return we && (rd != 0) &&
           ((uses_rs1_id && rs1_id == rd) || (uses_rs2_id && rs2_id == rd));
  endfunction

  function automatic logic [1:0] fwd_of(input bit fwd, input logic [AW-1:0] rs);
    if (!fwd) return 2'b00;
    if (regwrite_mem && rd_mem != 0 && rd_mem == rs) return 2'b10;
    if (regwrite_wb && rd_wb != 0 && rd_wb == rs) return 2'b01;
    return 2'b00;
  endfunction

  // pend = load bubbles still owed after this cycle's decision
  task automatic model(input int ls, input bit fwd, input int cmax,
                       inout int pend, inout int ns, inout int nf, output logic [10:0] ctl);
    logic [6:0] c;
    bit lu, raw;
    if (!reset) begin
      ctl = {C_RESET, 4'b0000};
      return;
    end
    lu  = id_reads(rd_ex, memread_ex);
    raw = !fwd && (id_reads(rd_ex, regwrite_ex) || id_reads(rd_mem, regwrite_mem));
    if (mem_busy) begin
      c = C_FREEZE;
      ns = (ns < cmax) ? ns + 1 : cmax;
    end else if (pcsrc) begin
      c = C_BRANCH;
      pend = 0;
      nf = (nf < cmax) ? nf + 1 : cmax;
    end else if (pend > 0 || lu || raw) begin
      c = C_STALL;
      if (pend > 0) pend = pend - 1;
      else if (lu) pend = ls - 1;
      ns = (ns < cmax) ? ns + 1 : cmax;
    end else begin
      c = C_NORM;
    end
    ctl = {c, fwd_of(fwd, rs1_ex), fwd_of(fwd, rs2_ex)};
  endtask

  task automatic eval();
    #1;
    if (!reset) begin
      pend_a = 0; ns_a = 0; nf_a = 0;
      pend_b = 0; ns_b = 0; nf_b = 0;
    end
    es_a = ns_a; ef_a = nf_a; es_b = ns_b; ef_b = nf_b;
    model(3, 1'b1, 65535, pend_a, ns_a, nf_a, ea);
    model(1, 1'b0, 15, pend_b, ns_b, nf_b, eb);
  endtask

  task automatic clear_inputs();
    rs1_id = 0; rs2_id = 0; rs1_ex = 0; rs2_ex = 0; rd_ex = 0; rd_mem = 0; rd_wb = 0;
    uses_rs1_id = 0; uses_rs2_id = 0; memread_ex = 0; regwrite_ex = 0;
    regwrite_mem = 0; regwrite_wb = 0; pcsrc = 0; mem_busy = 0;
  endtask

  task automatic load_use_inputs();
    memread_ex = 1; rd_ex = 7; rs2_id = 7; uses_rs2_id = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 0;
    repeat (2) @(negedge clk);
    eval();
    checks++; if (ctl_a !== {C_RESET, 4'b0000}) begin fails++; $display("FAIL reset_ctl_a got=%b exp=%b", ctl_a, {C_RESET, 4'b0000}); end
    checks++; if (ctl_b !== {C_RESET, 4'b0000}) begin fails++; $display("FAIL reset_ctl_b got=%b exp=%b", ctl_b, {C_RESET, 4'b0000}); end
    checks++; if ({sc_a, fc_a, sc_b, fc_b} !== 40'd0) begin fails++; $display("FAIL reset_counters got=%0d/%0d/%0d/%0d exp=0", sc_a, fc_a, sc_b, fc_b); end
    @(negedge clk);
    reset = 1;
    eval();
    checks++; if (ctl_a !== {C_NORM, 4'b0000}) begin fails++; $display("FAIL reset_release_a got=%b exp=%b", ctl_a, {C_NORM, 4'b0000}); end
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    clear_inputs();
    rs1_ex = 5; rd_mem = 5; rd_wb = 5; regwrite_mem = 1; regwrite_wb = 1;
    eval();
    checks++; if (fa_a !== 2'b10) begin fails++; $display("FAIL fwd_mem_pri got=%b exp=10", fa_a); end
    checks++; if (fa_b !== 2'b00) begin fails++; $display("FAIL fwd_off_b got=%b exp=00", fa_b); end
    @(negedge clk);
    rd_mem = 0;
    eval();
    checks++; if (fa_a !== 2'b01) begin fails++; $display("FAIL fwd_wb got=%b exp=01", fa_a); end
    @(negedge clk);
    rs1_ex = 0; rs2_ex = 0; rd_mem = 0; rd_wb = 0;
    eval();
    checks++; if ({fa_a, fb_a} !== 4'b0000) begin fails++; $display("FAIL fwd_x0 got=%b exp=0000", {fa_a, fb_a}); end
    @(negedge clk);
    rs2_ex = 9; rd_mem = 9; regwrite_mem = 0; rd_wb = 9;
    eval();
    checks++; if (ctl_a !== ea) begin fails++; $display("FAIL fwd_b_model got=%b exp=%b", ctl_a, ea); end
    checks++; if (fb_a !== 2'b01) begin fails++; $display("FAIL fwd_b_wb got=%b exp=01", fb_a); end
  endtask

  task automatic test_load_use();
    int s0;
    s0 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clear_inputs();
      load_use_inputs();
      eval();
      if (i == 0) s0 = int'(sc_a);
      checks++; if ({st_a, fe_a} !== 2'b11) begin fails++; $display("FAIL load_use_stall cyc=%0d got=%b exp=11", i, {st_a, fe_a}); end
      checks++; if (ctl_b !== eb) begin fails++; $display("FAIL load_use_b cyc=%0d got=%b exp=%b", i, ctl_b, eb); end
    end
    @(negedge clk);
    clear_inputs();
    eval();
    checks++; if (ctl_a[10:4] !== C_NORM) begin fails++; $display("FAIL load_use_end got=%b exp=%b", ctl_a[10:4], C_NORM); end
    checks++; if (sc_a !== 16'(s0 + 3)) begin fails++; $display("FAIL load_use_count got=%0d exp=%0d", sc_a, s0 + 3); end
  endtask

  task automatic test_branch_lstall();
    int f0;
    @(negedge clk);
    clear_inputs();
    load_use_inputs();
    eval();
    f0 = int'(fc_a);
    @(negedge clk);
    pcsrc = 1;
    eval();
    checks++; if (ctl_a[10:4] !== C_BRANCH) begin fails++; $display("FAIL branch_lstall got=%b exp=%b", ctl_a[10:4], C_BRANCH); end
    @(negedge clk);
    clear_inputs();
    eval();
    checks++; if (ctl_a[10:4] !== C_NORM) begin fails++; $display("FAIL branch_to_run got=%b exp=%b", ctl_a[10:4], C_NORM); end
    checks++; if (fc_a !== 16'(f0 + 1)) begin fails++; $display("FAIL branch_count got=%0d exp=%0d", fc_a, f0 + 1); end
  endtask

  task automatic test_busy_lstall();
    int s0;
    s0 = 0;
    @(negedge clk);
    clear_inputs();
    load_use_inputs();
    eval();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_busy = 1;
      eval();
      if (i == 0) s0 = int'(sc_a);
      checks++; if (ctl_a[10:4] !== C_FREEZE) begin fails++; $display("FAIL busy_freeze cyc=%0d got=%b exp=%b", i, ctl_a[10:4], C_FREEZE); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clear_inputs();
      eval();
      checks++; if (ctl_a[10:4] !== C_STALL) begin fails++; $display("FAIL busy_resume cyc=%0d got=%b exp=%b", i, ctl_a[10:4], C_STALL); end
    end
    @(negedge clk);
    eval();
    checks++; if (st_a !== 1'b0) begin fails++; $display("FAIL busy_end got=%b exp=0", st_a); end
    checks++; if (sc_a !== 16'(s0 + 6)) begin fails++; $display("FAIL busy_count got=%0d exp=%0d", sc_a, s0 + 6); end
  endtask

  task automatic test_raw_nofwd();
    @(negedge clk);
    clear_inputs();
    rs1_id = 3; uses_rs1_id = 1; regwrite_ex = 1; rd_ex = 3; rs1_ex = 3;
    eval();
    checks++; if ({st_b, fa_b, fb_b} !== 5'b10000) begin fails++; $display("FAIL raw_ex got=%b exp=10000", {st_b, fa_b, fb_b}); end
    checks++; if (st_a !== 1'b0) begin fails++; $display("FAIL raw_ex_fwd got=%b exp=0", st_a); end
    @(negedge clk);
    regwrite_ex = 0; rd_ex = 0; regwrite_mem = 1; rd_mem = 3;
    eval();
    checks++; if ({st_b, fa_b, fb_b} !== 5'b10000) begin fails++; $display("FAIL raw_mem got=%b exp=10000", {st_b, fa_b, fb_b}); end
    @(negedge clk);
    regwrite_mem = 0; rd_mem = 0; regwrite_wb = 1; rd_wb = 3;
    eval();
    checks++; if ({st_b, fa_b, fb_b} !== 5'b00000) begin fails++; $display("FAIL raw_wb got=%b exp=00000", {st_b, fa_b, fb_b}); end
    checks++; if (ctl_b !== eb) begin fails++; $display("FAIL raw_wb_model got=%b exp=%b", ctl_b, eb); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      clear_inputs();
      mem_busy = 1;
      eval();
      checks++; if (ctl_b !== eb) begin fails++; $display("FAIL sat_ctl cyc=%0d got=%b exp=%b", i, ctl_b, eb); end
    end
    @(negedge clk);
    eval();
    checks++; if (sc_b !== 4'd15) begin fails++; $display("FAIL sat_count got=%0d exp=15", sc_b); end
    #2;
    reset = 0;
    eval();
    checks++; if ({fi_a, fe_a, fm_a, fi_b, fe_b, fm_b} !== 6'b111111) begin fails++; $display("FAIL async_flush got=%b exp=111111", {fi_a, fe_a, fm_a, fi_b, fe_b, fm_b}); end
    checks++; if ({sc_a, fc_a, sc_b, fc_b} !== 40'd0) begin fails++; $display("FAIL async_counters got=%0d/%0d/%0d/%0d exp=0", sc_a, fc_a, sc_b, fc_b); end
    @(negedge clk);
    clear_inputs();
    reset = 1;
    eval();
    checks++; if (ctl_a !== {C_NORM, 4'b0000}) begin fails++; $display("FAIL after_mwait_reset got=%b exp=%b", ctl_a, {C_NORM, 4'b0000}); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rs1_id = AW'($urandom_range(0, 3)); rs2_id = AW'($urandom_range(0, 3));
      rs1_ex = AW'($urandom_range(0, 3)); rs2_ex = AW'($urandom_range(0, 3));
      rd_ex  = AW'($urandom_range(0, 3)); rd_mem = AW'($urandom_range(0, 3));
      rd_wb  = AW'($urandom_range(0, 3));
      uses_rs1_id  = ($urandom_range(0, 1) == 1); uses_rs2_id = ($urandom_range(0, 1) == 1);
      memread_ex   = ($urandom_range(0, 2) == 0); regwrite_ex = ($urandom_range(0, 1) == 1);
      regwrite_mem = ($urandom_range(0, 1) == 1); regwrite_wb = ($urandom_range(0, 1) == 1);
      pcsrc    = ($urandom_range(0, 9) == 0);
      mem_busy = ($urandom_range(0, 7) == 0);
      eval();
      checks++; if (ctl_a !== ea) begin fails++; $display("FAIL rand_ctl_a cyc=%0d got=%b exp=%b", i, ctl_a, ea); end
      checks++; if (ctl_b !== eb) begin fails++; $display("FAIL rand_ctl_b cyc=%0d got=%b exp=%b", i, ctl_b, eb); end
      checks++; if ({sc_a, fc_a} !== {16'(es_a), 16'(ef_a)}) begin fails++; $display("FAIL rand_cnt_a cyc=%0d got=%0d/%0d exp=%0d/%0d", i, sc_a, fc_a, es_a, ef_a); end
      checks++; if ({sc_b, fc_b} !== {4'(es_b), 4'(ef_b)}) begin fails++; $display("FAIL rand_cnt_b cyc=%0d got=%0d/%0d exp=%0d/%0d", i, sc_b, fc_b, es_b, ef_b); end
    end
  endtask

  initial begin
    pend_a = 0; ns_a = 0; nf_a = 0; pend_b = 0; ns_b = 0; nf_b = 0;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_lstall();
    test_busy_lstall();
    test_raw_nofwd();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter LOAD_STALL, default 1, legal 1..3, bubble cycles per load-use hazard.
REQ-003 SHALL have parameter FWD_ENABLE, default 1; 0 resolves RAW hazards by stalling instead of forwarding.
REQ-004 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- rs1_id, rs2_id  in  REG_AW  ID-stage source registers
- uses_rs1_id, uses_rs2_id  in  1  ID instruction reads the source
- rs1_ex, rs2_ex, rd_ex  in  REG_AW  EX-stage registers
- memread_ex, regwrite_ex  in  1  EX-stage controls
- rd_mem, regwrite_mem  in  REG_AW / 1  MEM-stage destination and write enable
- rd_wb, regwrite_wb  in  REG_AW / 1  WB-stage destination and write enable
- pcsrc  in  1  taken branch resolved in MEM
- mem_busy  in  1  data memory not ready this cycle
- pc_write, if_id_write  out  1  PC and IF/ID write enables
- stage_en  out  1  ID/EX, EX/MEM, MEM/WB write enable
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  synchronous clear of those registers
- forwardA, forwardB  out  2  ALU operand select: 00 regfile, 10 MEM, 01 WB
- pipeline_stall  out  1  bubble inserted this cycle
- stall_cycles, flush_events  out  CNT_W  saturating performance counters

Function
REQ-006 SHALL implement FSM states RUN, LSTALL, MWAIT, plus registers ret_state and cnt.
REQ-007 SHALL treat register 0 as never produced: no forward, no hazard.
REQ-008 SHALL, with FWD_ENABLE=1, set forwardA to 10 if regwrite_mem and rd_mem==rs1_ex; else 01 if regwrite_wb and rd_wb==rs1_ex; else 00. forwardB uses rs2_ex. Both outputs are combinational.
REQ-009 SHALL, with FWD_ENABLE=0, hold forwardA/forwardB at 00. A RAW match of a used ID source against a writing EX or MEM destination SHALL raise a stall (REQ-011 outputs) for every cycle the match persists. A WB match causes no stall; the register file writes before it reads.
REQ-010 SHALL detect load-use in RUN as: memread_ex, rd_ex!=0, and rd_ex matches a used ID source.
REQ-011 SHALL drive the following on every stall cycle: pipeline_stall=1, pc_write=0, if_id_write=0, id_ex_flush=1, stage_en=1.
REQ-012 SHALL, on load-use with LOAD_STALL>1, go RUN->LSTALL with cnt=LOAD_STALL-1. LSTALL repeats the REQ-011 outputs each cycle, decrements cnt, and returns to RUN in the cycle cnt==1. Zero-latency response occurs in the detecting cycle.
REQ-013 SHALL, on pcsrc in RUN or LSTALL, assert if_id_flush, id_ex_flush and ex_mem_flush that cycle, with pc_write=1 and pipeline_stall=0. Any remaining LSTALL is abandoned (next state RUN, cnt=0).
REQ-014 SHALL, on mem_busy in RUN or LSTALL, save the current state to ret_state and go MWAIT. This has priority over pcsrc and load-use in the same cycle.
REQ-015 SHALL, in MWAIT, drive pc_write=0, if_id_write=0, stage_en=0, all flushes 0, pipeline_stall=0, with cnt frozen. It SHALL return to ret_state in the first cycle mem_busy=0, and that cycle's pcsrc/hazard evaluation applies normally.
REQ-016 SHALL apply the priority order: mem_busy > pcsrc > load-use > FWD_ENABLE=0 RAW stall.
REQ-017 SHALL increment stall_cycles in each cycle with pipeline_stall=1 or state MWAIT, and flush_events in each REQ-013 cycle. Both saturate at all-ones with no wrap.
REQ-018 SHALL, in RUN with no event, drive pc_write=if_id_write=stage_en=1, all flushes 0 and pipeline_stall=0.

Reset
REQ-019 SHALL, while reset=0, asynchronously force: state RUN, ret_state RUN, cnt 0, counters 0, pc_write=if_id_write=stage_en=0, all flushes 1, forwardA=forwardB=00, pipeline_stall=0.
REQ-020 SHALL resume REQ-018 behaviour in the first clk edge after reset deasserts. Reset mid-LSTALL or mid-MWAIT discards that state.

Structure
REQ-021 SHALL take the FSM state enum and the forward encodings (FWD_REG=00, FWD_MEM=10, FWD_WB=01) from shared package riscv_pkg.
REQ-022 SHALL instantiate sub-module fwd_select twice, once for operand A and once for operand B.

Verification
REQ-023 Forwarding: rs1_ex=5, rd_mem=5 and rd_wb=5, both writing -> forwardA=10. Same case with rd_mem=0 -> forwardA=01.
REQ-024 Load-use, LOAD_STALL=3: memread_ex, rd_ex=7, rs2_id=7 used -> exactly 3 cycles of pipeline_stall=1 and id_ex_flush=1, then RUN; stall_cycles increases by 3.
REQ-025 Branch during LSTALL: pcsrc in the 2nd stall cycle -> three flushes high that cycle, pc_write=1, next state RUN, flush_events increases by 1.
REQ-026 mem_busy high for 4 cycles during LSTALL with cnt=2 -> stage_en=0 for 4 cycles, then 2 more stall cycles; stall_cycles increases by 4+2 for the remainder.
REQ-027 FWD_ENABLE=0: rs1_id=3 used, regwrite_ex, rd_ex=3 -> stall; the producer reaches MEM -> stall continues; it reaches WB -> no stall; forwards stay 00.
REQ-028 Counter saturation with CNT_W=4: 20 stall cycles -> stall_cycles=15. Reset pulse mid-MWAIT -> all counters 0 and flushes high asynchronously.
